// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared defaults and state encoding for the two-port memory
//                arbiter (mem_arb, mem_arb_rr).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DWIDTH_DEF   = 32;
    localparam int MEMSIZE_DEF  = 10;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// ============================================================================
//  Module      : mem_arb_rr
//  Description : Ownership arbitration for mem_arb. Computes the next owner,
//                tracks the last owner for round-robin tie breaking and
//                counts consecutive grant cycles to bound ownership.
//                Optional: MEM_ARB_FIXED_PRIO_EN - port 0 always wins ties
//                and is never preempted; only port 1 ownership is bounded.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_rr
    import mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic   clk,
    input  logic   xrst,
    input  logic   req0,
    input  logic   req1,
    input  logic   lock0,
    input  logic   lock1,
    input  state_t state,
    output state_t next_state
);

    localparam int              HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt;
    logic          hold_done;
    logic          gnt_any;
    logic          entering;

    assign hold_done = (hold_cnt == HOLD_LAST);
    assign gnt_any   = ((state == ST_OWN0) && req0) || ((state == ST_OWN1) && req1);
    // Any move into an owner state, including a direct owner-to-owner handover
    assign entering  = (next_state != state) && (next_state != ST_IDLE);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_lock0;
    assign unused_lock0 = lock0;

    // Next owner: port 0 wins ties and keeps ownership while it requests
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req0)      next_state = ST_OWN0;
                else if (req1) next_state = ST_OWN1;
            end
            ST_OWN0: begin
                if (!req0) next_state = req1 ? ST_OWN1 : ST_IDLE;
            end
            ST_OWN1: begin
                if (!req1 || (hold_done && req0 && !lock1))
                    next_state = req0 ? ST_OWN0 : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end
`else
    // rr_last = 1 means port 1 owned last, so port 0 wins the next tie
    logic rr_last;

    // Next owner: round-robin ties, bounded ownership unless the owner locks
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req0 && req1) next_state = rr_last ? ST_OWN0 : ST_OWN1;
                else if (req0)    next_state = ST_OWN0;
                else if (req1)    next_state = ST_OWN1;
            end
            ST_OWN0: begin
                if (!req0 || (hold_done && req1 && !lock0))
                    next_state = req1 ? ST_OWN1 : ST_IDLE;
            end
            ST_OWN1: begin
                if (!req1 || (hold_done && req0 && !lock1))
                    next_state = req0 ? ST_OWN0 : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Remember which port owned last, updated on every exit from an owner state
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rr_last <= 1'b1;
        end else if ((state == ST_OWN0) && (next_state != ST_OWN0)) begin
            rr_last <= 1'b0;
        end else if ((state == ST_OWN1) && (next_state != ST_OWN1)) begin
            rr_last <= 1'b1;
        end
    end
`endif

    // Consecutive grant counter: clears on entry, saturates at MAX_HOLD-1
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            hold_cnt <= '0;
        end else if (entering) begin
            hold_cnt <= '0;
        end else if (gnt_any && !hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arb.sv
// ============================================================================
//  Module      : mem_arb
//  Description : Two-port arbiter sharing one single-port memory (1-cycle
//                read latency). Port 0 is the AXI slave side, port 1 the
//                compute core. Grants one owner per cycle, muxes the memory
//                interface and returns read data to the issuing port.
//                Optional: MEM_ARB_FIXED_PRIO_EN (see mem_arb_rr).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int MEMSIZE  = MEMSIZE_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               req0,
    input  logic               lock0,
    input  logic               we0,
    input  logic [MEMSIZE-1:0] addr0,
    input  logic [DWIDTH-1:0]  wdata0,
    output logic               gnt0,
    output logic               rvalid0,
    output logic [DWIDTH-1:0]  rdata0,
    input  logic               req1,
    input  logic               lock1,
    input  logic               we1,
    input  logic [MEMSIZE-1:0] addr1,
    input  logic [DWIDTH-1:0]  wdata1,
    output logic               gnt1,
    output logic               rvalid1,
    output logic [DWIDTH-1:0]  rdata1,
    output logic               mem_we,
    output logic [MEMSIZE-1:0] mem_addr,
    output logic [DWIDTH-1:0]  mem_wdata,
    input  logic [DWIDTH-1:0]  mem_rdata
);

    state_t state;
    state_t next_state;

    mem_arb_rr #(
        .MAX_HOLD (MAX_HOLD)
    ) u_rr (
        .clk        (clk),
        .xrst       (xrst),
        .req0       (req0),
        .req1       (req1),
        .lock0      (lock0),
        .lock1      (lock1),
        .state      (state),
        .next_state (next_state)
    );

    // Owner state register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign gnt0 = (state == ST_OWN0) && req0;
    assign gnt1 = (state == ST_OWN1) && req1;

    // Route the owner's request onto the memory; idle drives all zeros
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_OWN0: begin
                mem_we    = gnt0 && we0;
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end
            ST_OWN1: begin
                mem_we    = gnt1 && we1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end
            default: ;
        endcase
    end

    // Read-valid follows the port that issued the read, even across a handover
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
        end
    end

    // Memory data is shared; each port qualifies it with its own rvalid
    assign rdata0 = mem_rdata;
    assign rdata1 = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// ============================================================================
//  Module      : tb_mem_arb
//  Description : Directed self-checking bench for mem_arb with a 1-cycle
//                latency memory model. Honours MEM_ARB_FIXED_PRIO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arb;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          xrst;
    logic          req0, lock0, we0, req1, lock1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          tb_load;
    logic [AW-1:0] tb_load_addr;
    logic [DW-1:0] tb_load_data;

    int n_cmp = 0;
    int n_err = 0;

    mem_arb #(.DWIDTH(DW), .MEMSIZE(AW), .MAX_HOLD(16)) dut (
        .clk(clk), .xrst(xrst),
        .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory model, read data one cycle after the address
    always @(posedge clk) begin
        if (mem_we)       mem[mem_addr] <= mem_wdata;
        else if (tb_load) mem[tb_load_addr] <= tb_load_data;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; lock0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; lock1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        xrst = 1'b0;
        clear_inputs();
        step();
        step();
        xrst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp0, prev0;

        // ---- Reset state, memory preload ----
        xrst = 1'b0;
        clear_inputs();
        tb_load = 1'b1; tb_load_addr = 10'h005; tb_load_data = 32'hDEADBEEF;
        req0 = 1; addr0 = 10'h007;
        step();
        step();
        tb_load = 1'b0;
        check("rst_gnt0",     gnt0,     0);
        check("rst_rvalid0",  rvalid0,  0);
        check("rst_mem_we",   mem_we,   0);
        check("rst_mem_addr", mem_addr, 0);
        xrst = 1'b1;
        step();
        check("rel_gnt0",     gnt0,     1);
        check("rel_mem_addr", mem_addr, 10'h007);
        req0 = 0;
        step();                                 // back to IDLE

        // ---- Single read on port 1 ----
        req1 = 1; we1 = 0; addr1 = 10'h005;
        #1;
        check("idle_gnt1", gnt1, 0);
        step();
        check("rd_gnt1",     gnt1,     1);
        check("rd_mem_addr", mem_addr, 10'h005);
        check("rd_mem_we",   mem_we,   0);
        step();
        req1 = 0;
        #1;
        check("rd_rvalid1", rvalid1, 1);
        check("rd_rdata1",  rdata1,  32'hDEADBEEF);
        check("rd_rvalid0", rvalid0, 0);
        step();
        check("rd_rvalid1_end", rvalid1, 0);

        // ---- Reset discards an in-flight rvalid ----
        req1 = 1; addr1 = 10'h005;
        step();
        step();
        check("mid_rvalid1_set", rvalid1, 1);
        xrst = 1'b0;
        #1;
        check("mid_rvalid1_clr", rvalid1, 0);
        check("mid_gnt1_clr",    gnt1,    0);
        do_reset();

        // ---- Tie from IDLE with bounded ownership ----
        req0 = 1; req1 = 1;
        prev0 = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int c = 1; c <= 50; c++) begin
            step();
            check($sformatf("fp_gnt0_c%0d", c), gnt0, 1);
            check($sformatf("fp_gnt1_c%0d", c), gnt1, 0);
        end
`else
        for (int c = 1; c <= 40; c++) begin
            step();
            exp0 = (((c - 1) / 16) % 2) == 0;
            check($sformatf("tie_gnt0_c%0d", c), gnt0, exp0);
            check($sformatf("tie_gnt1_c%0d", c), gnt1, !exp0);
            if (c > 1) begin
                check($sformatf("tie_rvalid0_c%0d", c), rvalid0, prev0);
                check($sformatf("tie_rvalid1_c%0d", c), rvalid1, !prev0);
            end
            prev0 = exp0;
        end
`endif
        do_reset();

        // ---- Lock holds ownership past MAX_HOLD ----
        req0 = 1; lock0 = 1; req1 = 1;
        for (int c = 1; c <= 40; c++) begin
            step();
            check($sformatf("lock_gnt0_c%0d", c), gnt0, 1);
            check($sformatf("lock_gnt1_c%0d", c), gnt1, 0);
        end
        lock0 = 0;
        step();
`ifdef MEM_ARB_FIXED_PRIO_EN
        check("unlock_gnt0", gnt0, 1);
        check("unlock_gnt1", gnt1, 0);
`else
        check("unlock_gnt0", gnt0, 0);
        check("unlock_gnt1", gnt1, 1);
`endif
        do_reset();

        // ---- Port 0 write, then port 1 reads it back ----
        req0 = 1; we0 = 1; addr0 = 10'h003; wdata0 = 32'h12345678;
        step();
        check("wr_gnt0",      gnt0,      1);
        check("wr_mem_we",    mem_we,    1);
        check("wr_mem_addr",  mem_addr,  10'h003);
        check("wr_mem_wdata", mem_wdata, 32'h12345678);
        step();
        req0 = 0; we0 = 0;
        req1 = 1; we1 = 0; addr1 = 10'h003;
        #1;
        check("wr_rvalid0", rvalid0, 0);
        check("wr_idle_we", mem_we,  0);
        step();
        check("sw_gnt1",     gnt1,     1);
        check("sw_gnt0",     gnt0,     0);
        check("sw_mem_addr", mem_addr, 10'h003);
        step();
        req1 = 0;
        #1;
        check("sw_rvalid1", rvalid1, 1);
        check("sw_rdata1",  rdata1,  32'h12345678);
        check("sw_rvalid0", rvalid0, 0);
        step();
        step();
        check("end_mem_addr", mem_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
